// File: rtl/raxm_arbiter.sv
// Two-requester round-robin front end for a shared approximate multiplier.
// One operation at a time: IDLE -> ISSUE -> WAIT -> RESP, with a WAIT-cycle timeout.
module raxm_arbiter #(
    parameter int          WIDTH         = 16,
    parameter int          TIMEOUT       = 255,
    parameter logic [15:0] OP_COUNT_INIT = 16'h0000
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 a_req,
    input  logic [WIDTH-1:0]     a_op_a,
    input  logic [WIDTH-1:0]     a_op_b,
    input  logic [1:0]           a_mode,
    output logic                 a_gnt,
    output logic                 a_done,
    output logic [2*WIDTH-1:0]   a_result,
    input  logic                 b_req,
    input  logic [WIDTH-1:0]     b_op_a,
    input  logic [WIDTH-1:0]     b_op_b,
    input  logic [1:0]           b_mode,
    output logic                 b_gnt,
    output logic                 b_done,
    output logic [2*WIDTH-1:0]   b_result,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    output logic [1:0]           mul_mode,
    input  logic                 mul_done,
    input  logic [2*WIDTH-1:0]   mul_result,
    input  logic                 err_clr,
    output logic                 err_timeout,
    output logic [15:0]          op_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_owner;
    logic               r_last;
    logic [7:0]         r_wait_cnt;
    logic [WIDTH-1:0]   r_mul_a;
    logic [WIDTH-1:0]   r_mul_b;
    logic [1:0]         r_mul_mode;
    logic               r_err;
    logic [15:0]        r_op_count;

    logic               w_any_req;
    logic               w_pick_b;
    logic               w_wait_last;
    logic               w_complete;
    logic               w_timeout;
    logic [1:0]         w_gnt;
    logic [1:0]         w_done;
    logic [2*WIDTH-1:0] w_result [2];

    assign w_any_req   = a_req | b_req;
    // r_last is the requester served most recently; 1 (B) out of reset so A wins the first tie.
    assign w_pick_b    = b_req & (~a_req | ~r_last);
    assign w_wait_last = (r_wait_cnt == LP_TMO_LAST);
    assign w_complete  = (r_state == ST_WAIT) & mul_done;
    assign w_timeout   = (r_state == ST_WAIT) & ~mul_done & w_wait_last;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_any_req) w_state_next = ST_ISSUE;
            ST_ISSUE: w_state_next = ST_WAIT;
            ST_WAIT:  if (w_complete || w_timeout) w_state_next = ST_RESP;
            ST_RESP:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_state    <= ST_IDLE;
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_wait_cnt <= 8'd0;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_mul_mode <= 2'd0;
            r_op_count <= OP_COUNT_INIT;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner    <= w_pick_b;
                        r_mul_a    <= w_pick_b ? b_op_a : a_op_a;
                        r_mul_b    <= w_pick_b ? b_op_b : a_op_b;
                        r_mul_mode <= w_pick_b ? b_mode : a_mode;
                    end
                end
                ST_ISSUE: r_wait_cnt <= 8'd0;
                ST_WAIT: begin
                    if (!w_complete && !w_timeout) r_wait_cnt <= r_wait_cnt + 8'd1;
                end
                ST_RESP: begin
                    r_last     <= r_owner;
                    r_op_count <= r_op_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // A timeout in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            localparam logic LP_ID = 1'(gi);
            logic [2*WIDTH-1:0] r_result;

            always_ff @(posedge wb_clk_i) begin
                if (!wb_rst_ni) begin
                    r_result <= '0;
                end else if (r_owner == LP_ID) begin
                    if (w_complete) begin
                        r_result <= mul_result;
                    end else if (w_timeout) begin
                        r_result <= '0;
                    end
                end
            end

            assign w_gnt[gi]    = (r_state == ST_ISSUE) && (r_owner == LP_ID);
            assign w_done[gi]   = (r_state == ST_RESP)  && (r_owner == LP_ID);
            assign w_result[gi] = r_result;
        end
    endgenerate

    assign a_gnt       = w_gnt[0];
    assign b_gnt       = w_gnt[1];
    assign a_done      = w_done[0];
    assign b_done      = w_done[1];
    assign a_result    = w_result[0];
    assign b_result    = w_result[1];
    assign mul_start   = (r_state == ST_ISSUE);
    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign mul_mode    = r_mul_mode;
    assign err_timeout = r_err;
    assign op_count    = r_op_count;

endmodule

// File: tb/tb_raxm_arbiter.sv
// Bench for raxm_arbiter: acts as both requesters and the shared multiplier,
// predicting grants, results, flags and counts from the arbitration rules.
module tb_raxm_arbiter;

    localparam int W   = 16;
    localparam int TMO = 4;

    logic           wb_clk_i = 1'b0;
    logic           wb_rst_ni;
    logic           a_req, b_req;
    logic [W-1:0]   a_op_a, a_op_b, b_op_a, b_op_b;
    logic [1:0]     a_mode, b_mode;
    logic           a_gnt, a_done, b_gnt, b_done;
    logic [2*W-1:0] a_result, b_result;
    logic           mul_start, mul_done;
    logic [W-1:0]   mul_a, mul_b;
    logic [1:0]     mul_mode;
    logic [2*W-1:0] mul_result;
    logic           err_clr, err_timeout;
    logic [15:0]    op_count;

    logic           wr_a_gnt, wr_a_done, wr_b_gnt, wr_b_done, wr_mul_start, wr_err_timeout;
    logic [2*W-1:0] wr_a_result, wr_b_result;
    logic [W-1:0]   wr_mul_a, wr_mul_b;
    logic [1:0]     wr_mul_mode;
    logic [15:0]    wr_op_count;

    always #5 wb_clk_i = ~wb_clk_i;

    raxm_arbiter #(.WIDTH(W), .TIMEOUT(TMO)) u_dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
        .a_req(a_req), .a_op_a(a_op_a), .a_op_b(a_op_b), .a_mode(a_mode),
        .a_gnt(a_gnt), .a_done(a_done), .a_result(a_result),
        .b_req(b_req), .b_op_a(b_op_a), .b_op_b(b_op_b), .b_mode(b_mode),
        .b_gnt(b_gnt), .b_done(b_done), .b_result(b_result),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_mode(mul_mode),
        .mul_done(mul_done), .mul_result(mul_result),
        .err_clr(err_clr), .err_timeout(err_timeout), .op_count(op_count)
    );

    // Second copy with the counter preloaded near its wrap point, fed the same stimulus.
    raxm_arbiter #(.WIDTH(W), .TIMEOUT(TMO), .OP_COUNT_INIT(16'hFFFE)) u_wrap (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
        .a_req(a_req), .a_op_a(a_op_a), .a_op_b(a_op_b), .a_mode(a_mode),
        .a_gnt(wr_a_gnt), .a_done(wr_a_done), .a_result(wr_a_result),
        .b_req(b_req), .b_op_a(b_op_a), .b_op_b(b_op_b), .b_mode(b_mode),
        .b_gnt(wr_b_gnt), .b_done(wr_b_done), .b_result(wr_b_result),
        .mul_start(wr_mul_start), .mul_a(wr_mul_a), .mul_b(wr_mul_b), .mul_mode(wr_mul_mode),
        .mul_done(mul_done), .mul_result(mul_result),
        .err_clr(err_clr), .err_timeout(wr_err_timeout), .op_count(wr_op_count)
    );

    int             n_checks = 0;
    int             n_fail   = 0;
    bit             exp_last_b;
    logic [15:0]    exp_cnt;
    logic [2*W-1:0] exp_res [2];
    bit             exp_err;

    function automatic logic [31:0] approx_mul(input logic [15:0] x, input logic [15:0] y,
                                               input logic [1:0] m);
        logic [31:0] p;
        p = {16'd0, x} * {16'd0, y};
        return p & (32'hFFFF_FFFF << (4 * m));
    endfunction

    task automatic tick;
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic do_reset;
        wb_rst_ni = 1'b0;
        a_req = 1'b0; b_req = 1'b0; mul_done = 1'b0; err_clr = 1'b0;
        a_op_a = '0; a_op_b = '0; a_mode = 2'd0;
        b_op_a = '0; b_op_b = '0; b_mode = 2'd0;
        mul_result = '0;
        tick;
        tick;
        wb_rst_ni  = 1'b1;
        exp_last_b = 1'b1;
        exp_cnt    = 16'd0;
        exp_res[0] = '0;
        exp_res[1] = '0;
        exp_err    = 1'b0;
    endtask

    // Multiplier model: answers in WAIT cycle k (never if k >= TMO); returns at the RESP cycle.
    task automatic mul_respond(input int k, output int waits);
        waits = -1;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (a_done || b_done) begin
                waits = i;
                break;
            end
            mul_done   = (i == k);
            mul_result = (i == k) ? approx_mul(mul_a, mul_b, mul_mode) : $urandom;
        end
        mul_done = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        n_checks++;
        if ({a_gnt, b_gnt, a_done, b_done, mul_start, err_timeout} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b want 000000",
                     {a_gnt, b_gnt, a_done, b_done, mul_start, err_timeout});
        end
        n_checks++;
        if ({a_result, b_result} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_results: got %h want 0", {a_result, b_result});
        end
        n_checks++;
        if ({mul_a, mul_b, mul_mode} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_mul_regs: got %h want 0", {mul_a, mul_b, mul_mode});
        end
        n_checks++;
        if (op_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_op_count: got %h want 0000", op_count);
        end
        $display("test_reset done");
    endtask

    task automatic test_single;
        do_reset;
        a_op_a = 16'd3; a_op_b = 16'd5; a_mode = 2'd0; a_req = 1'b1;
        tick;
        n_checks++;
        if ({a_gnt, b_gnt, mul_start} !== 3'b101) begin
            n_fail++;
            $display("FAIL single_grant_t1: got %b want 101", {a_gnt, b_gnt, mul_start});
        end
        a_req = 1'b0;
        tick;
        mul_done   = 1'b1;
        mul_result = approx_mul(mul_a, mul_b, mul_mode);
        n_checks++;
        if ({a_done, b_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_early_done: got %b want 00", {a_done, b_done});
        end
        tick;
        mul_done = 1'b0;
        n_checks++;
        if ({a_done, b_done} !== 2'b10 || a_result !== 32'd15) begin
            n_fail++;
            $display("FAIL single_done_t3: got done=%b result=%0d want done=10 result=15",
                     {a_done, b_done}, a_result);
        end
        tick;
        n_checks++;
        if (op_count !== 16'd1 || a_done !== 1'b0) begin
            n_fail++;
            $display("FAIL single_count: got count=%0d done=%b want count=1 done=0", op_count, a_done);
        end
        $display("test_single done: result=%0d count=%0d", a_result, op_count);
    endtask

    task automatic test_round_robin;
        int got;
        int waits;
        bit exp_b;
        bit both;
        both = 1'b0;
        do_reset;
        a_op_a = 16'($urandom); a_op_b = 16'($urandom); a_mode = 2'($urandom);
        b_op_a = 16'($urandom); b_op_b = 16'($urandom); b_mode = 2'($urandom);
        a_req = 1'b1; b_req = 1'b1;
        for (int j = 0; j < 4; j++) begin
            got = -1;
            for (int c = 0; c < 6; c++) begin
                tick;
                if (a_gnt && b_gnt) both = 1'b1;
                if (a_gnt || b_gnt) begin
                    got = b_gnt ? 1 : 0;
                    break;
                end
            end
            exp_b = !exp_last_b;
            n_checks++;
            if (got !== int'(exp_b)) begin
                n_fail++;
                $display("FAIL rr_order op%0d: got owner %0d want %0d", j, got, exp_b);
            end
            mul_respond(0, waits);
            if (a_done && b_done) both = 1'b1;
            n_checks++;
            if ({a_done, b_done} !== (exp_b ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL rr_done op%0d: got %b want %b", j, {a_done, b_done},
                         exp_b ? 2'b01 : 2'b10);
            end
            exp_last_b = exp_b;
            $display("test_round_robin op%0d owner=%s", j, exp_b ? "B" : "A");
            tick;
        end
        a_req = 1'b0; b_req = 1'b0;
        n_checks++;
        if (both !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_exclusive: got both-asserted=%b want 0", both);
        end
    endtask

    task automatic test_timeout;
        int waits;
        do_reset;
        a_op_a = 16'($urandom); a_op_b = 16'($urandom); a_mode = 2'($urandom); a_req = 1'b1;
        tick;
        a_req = 1'b0;
        mul_respond(99, waits);
        n_checks++;
        if (waits !== TMO || {a_done, a_result, err_timeout} !== {1'b1, 32'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL tmo_resp: got waits=%0d done=%b result=%h err=%b want %0d 1 0 1",
                     waits, a_done, a_result, err_timeout, TMO);
        end
        tick;
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        n_checks++;
        if (err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_clear: got %b want 0", err_timeout);
        end
        b_op_a = 16'($urandom); b_op_b = 16'($urandom); b_mode = 2'($urandom); b_req = 1'b1;
        tick;
        b_req = 1'b0;
        mul_respond(TMO - 1, waits);
        n_checks++;
        if (waits !== TMO || b_done !== 1'b1 || err_timeout !== 1'b0 ||
            b_result !== approx_mul(b_op_a, b_op_b, b_mode)) begin
            n_fail++;
            $display("FAIL tmo_boundary_done: got waits=%0d done=%b err=%b result=%h want %0d 1 0 %h",
                     waits, b_done, err_timeout, b_result, TMO, approx_mul(b_op_a, b_op_b, b_mode));
        end
        tick;
        a_req = 1'b1;
        tick;
        a_req = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            tick;
            err_clr = (i == TMO - 1);
        end
        tick;
        err_clr = 1'b0;
        n_checks++;
        if ({a_done, err_timeout} !== 2'b11) begin
            n_fail++;
            $display("FAIL tmo_set_wins: got done,err=%b want 11", {a_done, err_timeout});
        end
        tick;
        $display("test_timeout done: err=%b", err_timeout);
    endtask

    task automatic test_ignore;
        logic [W-1:0] ea, eb;
        logic [1:0]   em;
        bit           disturbed;
        disturbed = 1'b0;
        do_reset;
        for (int i = 0; i < 3; i++) begin
            mul_done   = 1'b1;
            mul_result = $urandom;
            tick;
            if ({a_done, b_done, mul_start, a_gnt, b_gnt} !== 5'b0) disturbed = 1'b1;
        end
        mul_done = 1'b0;
        n_checks++;
        if (disturbed || {a_result, b_result} !== 64'd0 || op_count !== 16'd0) begin
            n_fail++;
            $display("FAIL idle_stray_done: got pulses=%b results=%h count=%0d want 0 0 0",
                     disturbed, {a_result, b_result}, op_count);
        end
        ea = 16'($urandom); eb = 16'($urandom); em = 2'($urandom);
        a_op_a = ea; a_op_b = eb; a_mode = em; a_req = 1'b1;
        tick;
        a_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b_op_a = 16'($urandom); b_op_b = 16'($urandom); b_mode = 2'($urandom);
            tick;
            if ({mul_a, mul_b, mul_mode} !== {ea, eb, em}) disturbed = 1'b1;
            mul_done   = (i == 2);
            mul_result = approx_mul(mul_a, mul_b, mul_mode);
        end
        tick;
        mul_done = 1'b0;
        n_checks++;
        if (disturbed || {a_done, b_done} !== 2'b10 || a_result !== approx_mul(ea, eb, em)) begin
            n_fail++;
            $display("FAIL ignore_nonowner: got disturbed=%b done=%b result=%h want 0 10 %h",
                     disturbed, {a_done, b_done}, a_result, approx_mul(ea, eb, em));
        end
        tick;
        $display("test_ignore done");
    endtask

    task automatic test_reset_mid;
        bit pulse;
        int waits;
        pulse = 1'b0;
        do_reset;
        a_req = 1'b1;
        tick;
        a_req = 1'b0;
        tick;
        tick;
        wb_rst_ni = 1'b0;
        tick;
        wb_rst_ni  = 1'b1;
        mul_done   = 1'b1;
        mul_result = $urandom;
        for (int i = 0; i < 3; i++) begin
            if (a_done || b_done || mul_start) pulse = 1'b1;
            tick;
            mul_done = 1'b0;
        end
        n_checks++;
        if (pulse || op_count !== 16'd0 || a_result !== 32'd0) begin
            n_fail++;
            $display("FAIL rstmid_abandon: got pulse=%b count=%0d result=%h want 0 0 0",
                     pulse, op_count, a_result);
        end
        b_req = 1'b1;
        tick;
        b_req = 1'b0;
        n_checks++;
        if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_idle: got gnt a,b=%b want 01", {a_gnt, b_gnt});
        end
        mul_respond(0, waits);
        tick;
        $display("test_reset_mid done");
    endtask

    task automatic test_random(input int n);
        int             pat, lat, k, waits;
        bit             owner_b, tmo;
        logic [33:0]    exp_mul;
        logic [2*W-1:0] exp_prod;
        do_reset;
        for (int op = 0; op < n; op++) begin
            if ($urandom_range(0, 3) == 0) begin
                err_clr = 1'b1;
                tick;
                err_clr = 1'b0;
                exp_err = 1'b0;
            end
            pat = $urandom_range(1, 3);
            a_op_a = 16'($urandom); a_op_b = 16'($urandom); a_mode = 2'($urandom);
            b_op_a = 16'($urandom); b_op_b = 16'($urandom); b_mode = 2'($urandom);
            a_req = pat[0]; b_req = pat[1];
            owner_b  = (pat == 3) ? !exp_last_b : (pat == 2);
            exp_mul  = owner_b ? {b_op_a, b_op_b, b_mode} : {a_op_a, a_op_b, a_mode};
            exp_prod = owner_b ? approx_mul(b_op_a, b_op_b, b_mode) : approx_mul(a_op_a, a_op_b, a_mode);
            lat = -1;
            for (int c = 0; c < 6; c++) begin
                tick;
                if (a_gnt || b_gnt) begin
                    lat = c;
                    break;
                end
            end
            n_checks++;
            if (lat !== 0 || a_gnt !== !owner_b || b_gnt !== owner_b || mul_start !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_grant op%0d: got lat=%0d gnt a,b=%b start=%b want 0 %b 1",
                         op, lat, {a_gnt, b_gnt}, mul_start, {!owner_b, owner_b});
            end
            n_checks++;
            if ({mul_a, mul_b, mul_mode} !== exp_mul) begin
                n_fail++;
                $display("FAIL rand_operands op%0d: got %h want %h", op, {mul_a, mul_b, mul_mode}, exp_mul);
            end
            a_req = 1'b0; b_req = 1'b0;
            a_op_a = 16'($urandom); b_op_a = 16'($urandom); b_mode = 2'($urandom);
            k   = $urandom_range(0, 5);
            tmo = (k >= TMO);
            mul_respond(k, waits);
            exp_res[owner_b] = tmo ? '0 : exp_prod;
            if (tmo) exp_err = 1'b1;
            n_checks++;
            if (waits !== (tmo ? TMO : k + 1) || {a_done, b_done} !== {!owner_b, owner_b}) begin
                n_fail++;
                $display("FAIL rand_done op%0d: got waits=%0d done=%b want %0d %b",
                         op, waits, {a_done, b_done}, tmo ? TMO : k + 1, {!owner_b, owner_b});
            end
            n_checks++;
            if ({a_result, b_result} !== {exp_res[0], exp_res[1]} || err_timeout !== exp_err) begin
                n_fail++;
                $display("FAIL rand_results op%0d: got %h err=%b want %h err=%b", op,
                         {a_result, b_result}, err_timeout, {exp_res[0], exp_res[1]}, exp_err);
            end
            exp_last_b = owner_b;
            exp_cnt    = exp_cnt + 16'd1;
            tick;
            n_checks++;
            if (op_count !== exp_cnt) begin
                n_fail++;
                $display("FAIL rand_count op%0d: got %0d want %0d", op, op_count, exp_cnt);
            end
            $display("test_random op%0d owner=%s k=%0d timeout=%b result=%h",
                     op, owner_b ? "B" : "A", k, tmo, exp_res[owner_b]);
        end
    endtask

    task automatic test_wrap;
        logic [15:0] exp_w;
        int          waits;
        do_reset;
        exp_w = 16'hFFFE;
        n_checks++;
        if (wr_op_count !== exp_w) begin
            n_fail++;
            $display("FAIL wrap_init: got %h want %h", wr_op_count, exp_w);
        end
        for (int i = 0; i < 2; i++) begin
            a_req = 1'b1;
            tick;
            a_req = 1'b0;
            mul_respond(0, waits);
            tick;
            exp_w = exp_w + 16'd1;
            n_checks++;
            if (wr_op_count !== exp_w) begin
                n_fail++;
                $display("FAIL wrap_count op%0d: got %h want %h", i, wr_op_count, exp_w);
            end
            $display("test_wrap op%0d count=%h", i, wr_op_count);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_timeout;
        test_ignore;
        test_reset_mid;
        test_random(60);
        test_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/raxm_arbiter.md
RAXM_ARBITER -- requirements
Module: raxm_arbiter

Interface
REQ-001 Parameter WIDTH, default 16: operand width of each multiplier input; product width is 2*WIDTH.
REQ-002 Parameter TIMEOUT, default 255: maximum WAIT cycles before an operation is abandoned; legal range 1..255.
REQ-003 wb_clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 wb_rst_ni  in  1  reset, synchronous, active-low.
REQ-005 a_req  in  1  requester A (Wishbone side) operation request, level.
REQ-006 a_op_a, a_op_b  in  WIDTH each  requester A operands.
REQ-007 a_mode  in  2  requester A approximation level.
REQ-008 a_gnt  out  1  one-cycle pulse: A's operands captured.
REQ-009 a_done  out  1  one-cycle pulse: a_result valid.
REQ-010 a_result  out  2*WIDTH  last result delivered to A, held between pulses.
REQ-011 b_req, b_op_a, b_op_b, b_mode, b_gnt, b_done, b_result: requester B (logic-analyzer side), identical to REQ-005..REQ-010.
REQ-012 mul_start  out  1  one-cycle start pulse to the shared approximate multiplier.
REQ-013 mul_a, mul_b  out  WIDTH each; mul_mode  out  2: operands and mode, stable from mul_start until the operation ends.
REQ-014 mul_done  in  1  multiplier completion pulse; mul_result  in  2*WIDTH, valid with mul_done.
REQ-015 err_clr  in  1  clears err_timeout.
REQ-016 err_timeout  out  1  sticky timeout flag.
REQ-017 op_count  out  16  number of completed operations, including timeouts.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, RESP; all outputs registered or decoded from state only.
REQ-019 IDLE, no request pending: remain in IDLE.
REQ-020 IDLE, any request pending: select a requester, capture its operands and mode into mul_a/mul_b/mul_mode and the owner register, then go to ISSUE.
REQ-021 Requester selection, single request: grant that requester.
REQ-022 Requester selection, a_req and b_req both high: grant the requester not granted last (round-robin pointer).
REQ-023 ISSUE lasts exactly 1 cycle: mul_start=1 and the owner's gnt=1; the WAIT counter is cleared; then go to WAIT.
REQ-024 WAIT, mul_done=1: capture mul_result into the owner's result register, then go to RESP.
REQ-025 WAIT, counter increment: the counter increments each cycle without mul_done.
REQ-026 WAIT, timeout: when the counter reaches TIMEOUT with no mul_done, write 0 to the owner's result register, set err_timeout, then go to RESP.
REQ-027 mul_done outside WAIT: ignored.
REQ-028 mul_done in the same cycle the counter reaches TIMEOUT: treated as normal completion, err_timeout not set.
REQ-029 RESP lasts exactly 1 cycle: owner's done=1, round-robin pointer set to owner, op_count incremented (wraps 0xFFFF->0x0000), then go to IDLE.
REQ-030 Minimum latency: req seen in IDLE at cycle t; gnt/mul_start at t+1; mul_done at t+2; done at t+3; IDLE at t+4; next grant at t+5 at the earliest.
REQ-031 Requester obligation: hold operands and mode stable while req is high and gnt has not pulsed; req still high after done requests a new operation.
REQ-032 Non-owner requests: ignored until IDLE; operand changes by the non-owner never disturb mul_a, mul_b or mul_mode.
REQ-033 err_timeout set and err_clr in the same cycle: set wins.
REQ-034 gnt and done pulses: never asserted for both requesters in the same cycle.

Reset
REQ-035 While wb_rst_ni=0 at a clock edge: state=IDLE; round-robin pointer favours A; counters, err_timeout, op_count, a_result, b_result, mul_a, mul_b, mul_mode all 0; all pulse outputs 0.
REQ-036 Reset asserted mid-operation (ISSUE, WAIT or RESP): operation abandoned, no done pulse, op_count not incremented; a later stray mul_done is ignored.

Verification
REQ-037 Reset, then a_req=1 with a_op_a=3, a_op_b=5, and mul_done with mul_result=15 in the first WAIT cycle -> a_gnt at t+1, a_done at t+3, a_result=15, op_count=1.
REQ-038 a_req and b_req both held high from reset for 4 operations -> grant order A, B, A, B; no cycle with both gnt pulses.
REQ-039 TIMEOUT=4, mul_done never asserted -> owner done after 4 WAIT cycles, result=0, err_timeout=1; err_clr pulse -> 0; err_clr coincident with a new timeout -> stays 1.
REQ-040 mul_done pulsed while IDLE, and b_op_a changed while A owns the multiplier -> no state change, mul_a unchanged, no done pulse.
REQ-041 wb_rst_ni=0 during WAIT, then mul_done -> no done pulse, op_count=0, FSM in IDLE.
REQ-042 op_count preloaded to 0xFFFF by 65535 operations, then one more operation -> op_count=0x0000.
